// File: rtl/reset_seq_if.sv
`default_nettype none
// ====================================================================
// reset_seq_if - control/status bundle of the staged reset sequencer
// Rev 1.0
// ====================================================================
interface reset_seq_if #(
  parameter int NSTAGE = 4,
  parameter int FANOUT = 32,
  parameter int CW     = 16
);
  logic                     locked;
  logic                     sw_reset;
  logic [NSTAGE-1:0]        stage_en;
  logic [CW-1:0]            gap_cycles;
  logic [NSTAGE*FANOUT-1:0] stage_resetn;
  logic [NSTAGE-1:0]        stage_done;
  logic                     busy;
  logic                     all_done;
  logic [7:0]               seq_count;

  modport master (
    output locked, sw_reset, stage_en, gap_cycles,
    input  stage_resetn, stage_done, busy, all_done, seq_count
  );

  modport slave (
    input  locked, sw_reset, stage_en, gap_cycles,
    output stage_resetn, stage_done, busy, all_done, seq_count
  );
endinterface
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ====================================================================
// reset_seq - lock-gated, stage-by-stage reset release with fan-out copies
// Rev 1.0
// ====================================================================
module reset_seq #(
  parameter int NSTAGE   = 4,
  parameter int FANOUT   = 32,
  parameter int CW       = 16,
  parameter int MIN_HOLD = 64
) (
  input  wire logic  clk,
  input  wire logic  resetn,
  reset_seq_if.slave bus
);
  localparam int              c_IW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NSTAGE - 1);
  localparam logic [CW-1:0]   c_HOLD = CW'(MIN_HOLD);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RELEASE   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_hold, w_hold_nxt;
  logic [CW-1:0]     r_gap, w_gap_nxt;
  logic [CW-1:0]     w_gap_load;
  logic [c_IW-1:0]   r_idx, w_idx_nxt;
  logic [NSTAGE-1:0] w_rel_vec;
  logic              w_abort;
  logic              w_enter_done;
  logic              r_busy;
  logic              r_all_done;
  logic [7:0]        r_seq_count;

  assign w_gap_load = (bus.gap_cycles == '0) ? CW'(1) : bus.gap_cycles;
  assign w_abort    = bus.sw_reset || (!bus.locked && (r_state != S_WAIT_LOCK));

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_gap_nxt    = r_gap;
    w_idx_nxt    = r_idx;
    w_rel_vec    = '0;
    w_enter_done = 1'b0;
    if (w_abort) begin
      w_hold_nxt = '0;
      w_gap_nxt  = '0;
      w_idx_nxt  = '0;
      if (bus.sw_reset && bus.locked) begin
        w_state_nxt = S_HOLD;
        w_hold_nxt  = c_HOLD;
      end else begin
        w_state_nxt = S_WAIT_LOCK;
      end
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (bus.locked) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = c_HOLD;
          end
        end
        S_HOLD: begin
          if (r_hold == '0) begin
            w_state_nxt = S_RELEASE;
            w_idx_nxt   = '0;
            w_gap_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold - CW'(1);
          end
        end
        S_RELEASE: begin
          // The gap keeps running while masked stages are skipped, so a
          // disabled stage never stretches the spacing of enabled ones.
          if (r_gap != '0) w_gap_nxt = r_gap - CW'(1);
          if (!bus.stage_en[r_idx] || (r_gap <= CW'(1))) begin
            if (bus.stage_en[r_idx]) begin
              w_rel_vec[r_idx] = 1'b1;
              w_gap_nxt        = w_gap_load;
            end
            if (r_idx == c_LAST) begin
              w_state_nxt  = S_DONE;
              w_enter_done = 1'b1;
            end else begin
              w_idx_nxt = r_idx + c_IW'(1);
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_WAIT_LOCK;
      r_hold      <= '0;
      r_gap       <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b1;
      r_all_done  <= 1'b0;
      r_seq_count <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_gap      <= w_gap_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= (w_state_nxt != S_DONE);
      r_all_done <= (w_state_nxt == S_DONE);
      if (w_enter_done) r_seq_count <= r_seq_count + 8'd1;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    (* keep = "true", dont_touch = "true" *) logic [FANOUT-1:0] r_copy;
    logic r_done;

    always_ff @(posedge clk) begin
      if (!resetn || w_abort) begin
        r_copy <= '0;
        r_done <= 1'b0;
      end else if (w_rel_vec[k]) begin
        r_copy <= '1;
        r_done <= 1'b1;
      end
    end

    assign bus.stage_resetn[k*FANOUT +: FANOUT] = r_copy;
    assign bus.stage_done[k]                    = r_done;
  end

  assign bus.busy      = r_busy;
  assign bus.all_done  = r_all_done;
  assign bus.seq_count = r_seq_count;
endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ====================================================================
// tb_reset_seq - directed bench with a release-timeline reference model
// Rev 1.0
// ====================================================================
module tb_reset_seq;
  localparam int NSTAGE   = 4;
  localparam int FANOUT   = 32;
  localparam int CW       = 16;
  localparam int MIN_HOLD = 64;
  localparam int W        = NSTAGE * FANOUT;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  reset_seq_if #(.NSTAGE(NSTAGE), .FANOUT(FANOUT), .CW(CW)) bus ();

  reset_seq #(
    .NSTAGE  (NSTAGE),
    .FANOUT  (FANOUT),
    .CW      (CW),
    .MIN_HOLD(MIN_HOLD)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence start time plus the rule that one stage is
  // evaluated per cycle from start+MIN_HOLD+2, enabled ones only once the
  // previous release's gap has elapsed.
  int                cyc     = 0;
  int                m_phase = 0;   // 0 waiting for lock, 1 sequencing, 2 done
  int                m_t0    = 0;
  int                m_k     = 0;
  int                m_ready = 0;
  int                m_seq   = 0;
  logic [NSTAGE-1:0] m_rel   = '0;
  bit                chk_on  = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase = 0;
      m_rel   = '0;
      m_k     = 0;
      m_seq   = 0;
    end else if (bus.sw_reset || (!bus.locked && m_phase != 0)) begin
      m_rel   = '0;
      m_k     = 0;
      m_ready = 0;
      if (bus.sw_reset && bus.locked) begin
        m_phase = 1;
        m_t0    = cyc;
      end else begin
        m_phase = 0;
      end
    end else if (m_phase == 0) begin
      if (bus.locked) begin
        m_phase = 1;
        m_t0    = cyc;
        m_k     = 0;
        m_ready = 0;
      end
    end else if (m_phase == 1 && cyc >= m_t0 + MIN_HOLD + 2) begin
      if (!bus.stage_en[m_k]) begin
        m_k++;
      end else if (cyc >= m_ready) begin
        m_rel[m_k] = 1'b1;
        m_ready    = cyc + ((bus.gap_cycles == 0) ? 1 : int'(bus.gap_cycles));
        m_k++;
      end
      if (m_k == NSTAGE) begin
        m_phase = 2;
        m_seq   = (m_seq + 1) % 256;
      end
    end
    cyc++;
  end

  function automatic logic [W-1:0] exp_resetn(input logic [NSTAGE-1:0] rel);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NSTAGE; k++) if (rel[k]) v[k*FANOUT +: FANOUT] = '1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stage_resetn", bus.stage_resetn, exp_resetn(m_rel));
      chk("stage_done", W'(bus.stage_done), W'(m_rel));
      chk("all_done", W'(bus.all_done), W'(m_phase == 2));
      chk("busy", W'(bus.busy), W'(m_phase != 2));
      chk("seq_count", W'(bus.seq_count), W'(m_seq));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sw();
    bus.sw_reset = 1'b1;
    @(negedge clk);
    bus.sw_reset = 1'b0;
  endtask

  task automatic wait_stage(input int k, output int n);
    n = 0;
    while (bus.stage_resetn[k*FANOUT] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.all_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", W'(bus.all_done), W'(1));
  endtask

  int n;

  initial begin
    bus.locked     = 1'b0;
    bus.sw_reset   = 1'b0;
    bus.stage_en   = 4'hF;
    bus.gap_cycles = 16'd16;
    resetn         = 1'b0;
    tick(2);
    chk_on = 1'b1;
    tick(8);
    chk("rst_resetn", bus.stage_resetn, '0);
    chk("rst_busy", W'(bus.busy), W'(1));
    chk("rst_seq", W'(bus.seq_count), W'(0));

    // Power-up: lock loss in WAIT_LOCK is a no-op, then lock arrives
    resetn = 1'b1;
    tick(3);
    bus.locked = 1'b1;
    @(negedge clk);
    wait_stage(0, n); chk("pu_lat0", W'(n), W'(66));
    wait_stage(1, n); chk("pu_gap1", W'(n), W'(16));
    wait_stage(2, n); chk("pu_gap2", W'(n), W'(16));
    wait_stage(3, n); chk("pu_gap3", W'(n), W'(16));
    chk("pu_all_done", W'(bus.all_done), W'(1));
    chk("pu_seq", W'(bus.seq_count), W'(1));
    tick(4);

    // Software reset from DONE reruns through HOLD
    pulse_sw();
    chk("sw_clear", bus.stage_resetn, '0);
    chk("sw_busy", W'(bus.busy), W'(1));
    wait_stage(0, n); chk("sw_lat0", W'(n), W'(66));
    wait_done();
    chk("sw_seq", W'(bus.seq_count), W'(2));

    // Stage 2 masked off
    bus.stage_en = 4'b1011;
    pulse_sw();
    wait_stage(1, n);
    wait_stage(3, n); chk("mask_gap13", W'(n), W'(16));
    chk("mask_done", W'(bus.stage_done), W'(4'b1011));
    chk("mask_s2", W'(bus.stage_resetn[2*FANOUT +: FANOUT]), W'(0));
    tick(3);

    // Zero gap behaves as one cycle
    bus.stage_en   = 4'hF;
    bus.gap_cycles = 16'd0;
    pulse_sw();
    wait_stage(0, n);
    wait_stage(1, n); chk("gap0_1", W'(n), W'(1));
    wait_stage(2, n); chk("gap0_2", W'(n), W'(1));
    wait_stage(3, n); chk("gap0_3", W'(n), W'(1));
    tick(2);

    // Lock loss mid-release, then full restart on lock return
    bus.gap_cycles = 16'd16;
    pulse_sw();
    wait_stage(1, n);
    tick(3);
    bus.locked = 1'b0;
    @(negedge clk);
    chk("ll_clear", bus.stage_resetn, '0);
    chk("ll_done", W'(bus.stage_done), W'(0));
    tick(5);
    bus.locked = 1'b1;
    @(negedge clk);
    wait_stage(0, n); chk("ll_lat0", W'(n), W'(66));
    wait_done();
    chk("ll_seq", W'(bus.seq_count), W'(5));

    // Sequence counter wrap
    bus.gap_cycles = 16'd0;
    for (int i = 0; i < 250; i++) begin
      pulse_sw();
      wait_done();
    end
    chk("seq_255", W'(bus.seq_count), W'(255));
    pulse_sw();
    wait_done();
    chk("seq_wrap", W'(bus.seq_count), W'(0));

    // Block reset mid-sequence clears the counter too
    pulse_sw();
    wait_done();
    pulse_sw();
    wait_stage(0, n);
    resetn = 1'b0;
    @(negedge clk);
    chk("mr_seq", W'(bus.seq_count), W'(0));
    chk("mr_resetn", bus.stage_resetn, '0);
    chk("mr_busy", W'(bus.busy), W'(1));
    tick(2);
    resetn = 1'b1;
    wait_done();
    chk("mr_seq_after", W'(bus.seq_count), W'(1));
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised reset sequencer for the PL top level.
- Holds NSTAGE reset domains (cfg, dsp, ps, adc, ...) in reset, then releases them one at a time in ascending stage order, with a programmable gap between stages.
- Each stage output is registered and replicated FANOUT times to ease fan-out timing.
- Adds features a flat reset register does not have: PLL-lock gating, a software reset request, per-stage enable masking, and status/sequence counting.

Parameters:
- NSTAGE, 4, number of reset stages; release order is stage 0 first.
- FANOUT, 32, replicated active-low copies per stage.
- CW, 16, width of the hold and gap counters.
- MIN_HOLD, 64, cycles all stages stay asserted after lock is seen (1..2^CW-1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- resetn  in  1  synchronous, active-low block reset.
- locked  in  1  clock-source lock; must already be synchronous to clk.
- sw_reset  in  1  single-cycle software reset request.
- stage_en  in  NSTAGE  per-stage enable; a 0 bit keeps that stage in reset permanently.
- gap_cycles  in  CW  cycles between successive stage releases; 0 is treated as 1.
- stage_resetn  out  NSTAGE*FANOUT  bits [k*FANOUT +: FANOUT] are stage k's active-low resets.
- stage_done  out  NSTAGE  bit k = 1 once stage k has been released.
- busy  out  1  1 whenever the FSM is not in DONE.
- all_done  out  1  1 in DONE.
- seq_count  out  8  number of completed sequences; wraps at 255 -> 0.

Behaviour:
- Reset (resetn=0 at a clk edge), effective next edge:
  - FSM = WAIT_LOCK.
  - stage_resetn = all 0; stage_done = 0; busy = 1; all_done = 0; seq_count = 0.
  - Counters = 0.
- WAIT_LOCK: all stages asserted. When locked=1, load hold counter and go to HOLD.
- HOLD: all stages asserted. Count MIN_HOLD cycles with locked continuously 1, then go to RELEASE with stage index k=0.
- RELEASE:
  - If stage_en[k]=1, release stage k this cycle: its FANOUT bits go 1 and stage_done[k] goes 1 on the next edge.
  - After an enabled release, the gap counter loads max(gap_cycles,1). Stage k+1 is released exactly max(gap_cycles,1) cycles after stage k.
  - If stage_en[k]=0, skip it: it stays in reset, stage_done[k] stays 0, no gap is spent, and the FSM advances to k+1 next cycle.
  - After the last stage (k = NSTAGE-1) is handled, go to DONE.
- DONE: busy=0, all_done=1. seq_count increments once on entry.
- gap_cycles and stage_en are sampled when each stage is evaluated. Changes mid-sequence affect only stages not yet evaluated.
- Abort (sw_reset=1, or locked=0 in HOLD/RELEASE/DONE):
  - Next edge: all stage_resetn = 0, stage_done = 0, all_done = 0, busy = 1, counters cleared.
  - sw_reset with locked=1 goes to HOLD; otherwise go to WAIT_LOCK.
  - sw_reset has priority over every other transition.
- resetn=0 mid-sequence: immediate full reset as above; it also clears seq_count. An abort does not clear seq_count.
- Latency: from locked rising (sampled), stage 0 is released MIN_HOLD+2 cycles later, measured at stage_resetn.
- All outputs are registered; no combinational path from any input to any output.
- The FANOUT copies of a stage are identical, separate flops; synthesis must not merge them (keep/dont-touch attribute).
- Lock loss in WAIT_LOCK: no action.

Test Plan:
- Power-up: NSTAGE=4, MIN_HOLD=64, gap=16, stage_en=4'hF, resetn low 10 cycles, then locked high -> stage 0 releases at 66 cycles; stages 1..3 follow at +16 each; all_done=1 and seq_count=1 after stage 3.
- Mask: stage_en=4'b1011 -> stage 2 stays 0 permanently; stage 3 releases 16 cycles after stage 1; stage_done=4'b1011.
- gap_cycles=0 -> consecutive enabled stages release 1 cycle apart.
- sw_reset pulse in DONE with locked=1 -> all stage_resetn=0 next cycle; sequence reruns through HOLD; seq_count reaches 2.
- Lock loss while in RELEASE after stage 1 -> all outputs asserted next cycle, FSM in WAIT_LOCK; on lock return, the full sequence restarts from HOLD.
- seq_count wrap: 256 sw_reset-driven sequences -> seq_count goes 255 -> 0; resetn low mid-sequence -> seq_count=0 and all outputs at reset values.
